// File: rtl/req_ack_sync_pkg.sv
// Shared types and limits for the four-phase req/ack receive controller.
package req_ack_sync_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    ACK   = 2'd2
  } state_t;

  localparam int SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/req_ack_sync_ctrl_sync_chain.sv
// Single-bit N-flop synchronizer: latency STAGES clk edges, no backpressure.
// The first flop may go metastable; only the last flop is consumed downstream.
module sync_chain
  import req_ack_sync_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  if (STAGES < SYNC_STAGES_MIN) begin : g_stages_check
    $error("sync_chain needs at least %0d stages", SYNC_STAGES_MIN);
  end

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/req_ack_sync_ctrl.sv
// Four-phase req/ack receiver: req synchronized, word offered SYNC_STAGES+1 edges after req is
// sampled, held on data_valid until data_ready; ack raised on accept. Optional REQ_ACK_TIMEOUT_EN.
module req_ack_sync_ctrl
  import req_ack_sync_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_async,
  input  logic [DATA_W-1:0] data_async,
  input  logic              data_ready,
  output logic              ack,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              busy,
  output logic              err
);

  if (SYNC_STAGES < SYNC_STAGES_MIN || TIMEOUT_CYC < 1) begin : g_param_check
    $error("req_ack_sync_ctrl: illegal SYNC_STAGES or TIMEOUT_CYC");
  end

  logic req_sync;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (req_async),
    .q       (req_sync)
  );

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ack_q, ack_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;

  // data_async is only looked at on the IDLE->OFFER edge, where the source holds it stable.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (req_sync) begin
          data_d  = data_async;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (data_ready) begin
          state_d = ACK;
        end
      end
      ACK: begin
        if (!req_sync) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ack_d   = (state_d == ACK);
    valid_d = (state_d == OFFER);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign ack        = ack_q;
  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign busy       = busy_q;

`ifdef REQ_ACK_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Counter rests at zero outside ACK and saturates at the limit; the FSM keeps waiting.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q != ACK) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_W'(TIMEOUT_CYC)) begin
      cnt_d = cnt_q + 1'b1;
    end
    err_d = err_q | ((state_q == ACK) && (cnt_q == CNT_W'(TIMEOUT_CYC)));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_req_ack_sync_ctrl.sv
// Directed bench for req_ack_sync_ctrl with a word scoreboard and immediate assertions.
module tb_req_ack_sync_ctrl;

  logic       clk;
  logic       reset_n;
  logic       req_async;
  logic [7:0] data_async;
  logic       data_ready;
  logic       ack;
  logic [7:0] data_out;
  logic       data_valid;
  logic       busy;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] sb[$];

  req_ack_sync_ctrl #(
    .DATA_W      (8),
    .SYNC_STAGES (2),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_async  (req_async),
    .data_async (data_async),
    .data_ready (data_ready),
    .ack        (ack),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 12 && !data_valid; i++) step(1);
    check(tag, {31'b0, data_valid}, 32'd1);
  endtask

  task automatic wait_ack_low(input string tag);
    for (int i = 0; i < 12 && ack; i++) step(1);
    check(tag, {31'b0, ack}, 32'd0);
  endtask

  // Compare the offered word against the oldest expected word at the accepting cycle.
  task automatic accept(input string tag);
    logic [31:0] exp;
    exp = 'x;
    if (sb.size() > 0) exp = {24'b0, sb.pop_front()};
    check(tag, {24'b0, data_out}, exp);
  endtask

  initial begin
    reset_n    = 1'b0;
    req_async  = 1'b0;
    data_async = 8'h00;
    data_ready = 1'b0;
    #3;
    check("rst_ack",   {31'b0, ack},        32'd0);
    check("rst_valid", {31'b0, data_valid}, 32'd0);
    check("rst_busy",  {31'b0, busy},       32'd0);
    check("rst_data",  {24'b0, data_out},   32'd0);
    check("rst_err",   {31'b0, err},        32'd0);
    step(1);
    reset_n = 1'b1;
    step(1);

    // Single transfer with consumer always ready.
    data_async = 8'hA5;
    req_async  = 1'b1;
    data_ready = 1'b1;
    sb.push_back(8'hA5);
    step(2);
    check("t1_valid_early", {31'b0, data_valid}, 32'd0);
    step(1);
    check("t1_valid_k2", {31'b0, data_valid}, 32'd1);
    check("t1_busy", {31'b0, busy}, 32'd1);
    accept("t1_data");
    step(1);
    check("t1_valid_drop", {31'b0, data_valid}, 32'd0);
    check("t1_ack_hi", {31'b0, ack}, 32'd1);
    req_async = 1'b0;
    step(2);
    check("t1_ack_hold", {31'b0, ack}, 32'd1);
    step(1);
    check("t1_ack_lo", {31'b0, ack}, 32'd0);
    check("t1_busy_lo", {31'b0, busy}, 32'd0);

    // Backpressure on word 3C, which also opens the back-to-back pair.
    data_async = 8'h3C;
    data_ready = 1'b0;
    req_async  = 1'b1;
    sb.push_back(8'h3C);
    wait_valid("bp_valid");
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("bp_valid_hold", {31'b0, data_valid}, 32'd1);
      check("bp_data_hold",  {24'b0, data_out},   32'h3C);
      check("bp_ack_lo",     {31'b0, ack},        32'd0);
    end
    data_ready = 1'b1;
    accept("bp_data");
    step(1);
    check("bp_valid_drop", {31'b0, data_valid}, 32'd0);
    check("bp_ack_hi", {31'b0, ack}, 32'd1);
    req_async = 1'b0;
    wait_ack_low("bp_ack_lo_end");

    // Second word one cycle after ack falls.
    step(1);
    data_async = 8'h5A;
    req_async  = 1'b1;
    sb.push_back(8'h5A);
    wait_valid("b2b_valid");
    accept("b2b_data");
    step(1);
    check("b2b_ack_hi", {31'b0, ack}, 32'd1);
    req_async = 1'b0;
    wait_ack_low("b2b_ack_lo");
    step(4);
    check("b2b_no_dup", {31'b0, data_valid}, 32'd0);
    check("b2b_sb_empty", sb.size(), 32'd0);

    // Reset while in ACK with req still high; word is re-captured after release.
    data_async = 8'hC3;
    req_async  = 1'b1;
    sb.push_back(8'hC3);
    wait_valid("rs_valid");
    accept("rs_data");
    step(1);
    check("rs_ack_hi", {31'b0, ack}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rs_ack_async",   {31'b0, ack},        32'd0);
    check("rs_valid_async", {31'b0, data_valid}, 32'd0);
    check("rs_busy_async",  {31'b0, busy},       32'd0);
    check("rs_data_async",  {24'b0, data_out},   32'd0);
    check("rs_err_async",   {31'b0, err},        32'd0);
    data_ready = 1'b0;
    step(1);
    reset_n = 1'b1;
    sb.push_back(8'hC3);
    step(2);
    check("rs_valid_early", {31'b0, data_valid}, 32'd0);
    step(1);
    check("rs_valid_recap", {31'b0, data_valid}, 32'd1);
    data_ready = 1'b1;
    accept("rs_data_recap");
    step(1);
    check("rs_ack_recap", {31'b0, ack}, 32'd1);
    data_ready = 1'b0;

    // Source stalls with req high while ack is up.
`ifdef REQ_ACK_TIMEOUT_EN
    step(9);
    check("to_err_early", {31'b0, err}, 32'd0);
    step(10);
    check("to_err_set", {31'b0, err}, 32'd1);
    check("to_still_ack", {31'b0, ack}, 32'd1);
    req_async = 1'b0;
    wait_ack_low("to_ack_lo");
    check("to_busy_lo", {31'b0, busy}, 32'd0);
    check("to_err_sticky", {31'b0, err}, 32'd1);
`else
    step(19);
    check("nto_err_lo", {31'b0, err}, 32'd0);
    check("nto_still_ack", {31'b0, ack}, 32'd1);
    req_async = 1'b0;
    wait_ack_low("nto_ack_lo");
    check("nto_busy_lo", {31'b0, busy}, 32'd0);
    check("nto_err_end", {31'b0, err}, 32'd0);
`endif
    check("end_sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
